score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameters SHALL be: PONTOS_VITORIA, default 10, points needed to win (legal range 1..999); COOLDOWN, default 25_000_000, pause length in clk cycles after a point (legal range >= 1).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port `clk`: input, 1 bit, system clock; all state changes on its rising edge.
REQ-004 Port `reset`: input, 1 bit, asynchronous, active-high; clears all state.
REQ-005 Port `colisao1`: input, 1 bit, level; player 1 collided, so player 2 scores.
REQ-006 Port `colisao2`: input, 1 bit, level; player 2 collided, so player 1 scores.
REQ-007 Port `novo_jogo`: input, 1 bit, synchronous; when 1, clears scores and starts a new game.
REQ-008 Port `score1`: output, 10 bits, binary score of player 1; feeds the display's score1 input.
REQ-009 Port `score2`: output, 10 bits, binary score of player 2; feeds the display's score2 input.
REQ-010 Port `ponto`: output, 1 bit, one-cycle pulse in each cycle where any score changes.
REQ-011 Port `pausa`: output, 1 bit, 1 while in state PAUSA.
REQ-012 Port `fim_jogo`: output, 1 bit, 1 while in state FIM.
REQ-013 Port `vencedor`: output, 2 bits; 00 = none, 01 = player 1, 10 = player 2, 11 = tie.

Function
REQ-014 Synchronisation: colisao1 and colisao2 SHALL each pass through a one-flop synchroniser followed by a delay flop.
REQ-015 Edge detect: a rising edge SHALL be recognised when the synchronised value is 1 and the delayed value is 0; a level held high SHALL produce exactly one edge.
REQ-016 Latency: an accepted edge SHALL update the score at the second rising clk edge that samples the input high; ponto SHALL be high in the cycle after that update.
REQ-017 FSM: the states SHALL be JOGANDO, PAUSA and FIM; the reset state is JOGANDO.
REQ-018 In JOGANDO, an edge on colisao1 SHALL increment score2 by 1, and an edge on colisao2 SHALL increment score1 by 1.
REQ-019 Simultaneous edges on both inputs SHALL increment both scores in the same cycle.
REQ-020 After any increment, if no score has reached PONTOS_VITORIA, the FSM SHALL go to PAUSA and load the pause counter with COOLDOWN-1.
REQ-021 In PAUSA, the counter SHALL decrement every cycle; when it reaches 0, the FSM SHALL return to JOGANDO on the next edge, so PAUSA lasts exactly COOLDOWN cycles.
REQ-022 Edges occurring in PAUSA or FIM SHALL be discarded, not queued.
REQ-023 Win check: when an increment makes a score equal PONTOS_VITORIA, the FSM SHALL go to FIM and latch vencedor in the same edge as the score update.
REQ-024 vencedor SHALL be 01 if only score1 reached PONTOS_VITORIA, 10 if only score2 did, and 11 if both reached it on the same edge.
REQ-025 FIM SHALL hold the scores and vencedor until novo_jogo is asserted.
REQ-026 novo_jogo in any state SHALL, at the next edge, set both scores to 0 and vencedor to 00, clear the pause counter, and move the FSM to JOGANDO.
REQ-027 novo_jogo SHALL take priority over an edge detected in the same cycle; that edge SHALL be discarded.
REQ-028 Arithmetic: scores are unsigned 10-bit values that SHALL saturate at 999 and never wrap.
REQ-029 The outputs pausa and fim_jogo SHALL be decoded from registered state; all outputs SHALL be glitch-free register outputs.

Reset
REQ-030 While reset = 1, score1, score2, vencedor, the pause counter, and the synchroniser and delay flops SHALL be 0, ponto, pausa and fim_jogo SHALL be 0, and the FSM SHALL be in JOGANDO, regardless of clk.
REQ-031 A reset asserted mid-PAUSA or in FIM SHALL abort immediately to the reset values.
REQ-032 A colisao input held high through reset deassertion SHALL produce one edge, since the delay flop starts at 0.

Verification (PONTOS_VITORIA=3, COOLDOWN=4)
REQ-033 Single point: pulse colisao2 high for 1 cycle -> score1=1 two edges after sampling, ponto pulses once, pausa=1 for exactly 4 cycles, score2=0.
REQ-034 Held level: hold colisao1 high for 20 cycles -> score2 increments exactly once.
REQ-035 Pause discard: colisao2 edge during PAUSA -> score1 unchanged; after PAUSA a fresh edge -> score1 increments.
REQ-036 Win: three spaced colisao2 edges -> score1=3, fim_jogo=1, vencedor=01; a further colisao1 edge leaves score2 unchanged; then novo_jogo -> scores 0/0, vencedor=00, state JOGANDO.
REQ-037 Tie: bring scores to 2/2, then edges on both inputs in the same cycle -> scores 3/3, vencedor=11, fim_jogo=1.
REQ-038 Priority and async reset: novo_jogo coincident with a colisao1 edge -> score2 stays 0; reset asserted mid-PAUSA between clk edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/score_keeper_if.sv
// score_keeper_if: collision inputs, new-game request and score/status outputs of the score keeper
interface score_keeper_if;
   logic       colisao1;
   logic       colisao2;
   logic       novo_jogo;
   logic [9:0] score1;
   logic [9:0] score2;
   logic       ponto;
   logic       pausa;
   logic       fim_jogo;
   logic [1:0] vencedor;
   modport master (
      output colisao1, colisao2, novo_jogo,
      input  score1, score2, ponto, pausa, fim_jogo, vencedor
   );
   modport slave (
      input  colisao1, colisao2, novo_jogo,
      output score1, score2, ponto, pausa, fim_jogo, vencedor
   );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: counts points from collision edges, pauses after each point and latches the winner
module score_keeper #(
   parameter int PONTOS_VITORIA = 10,
   parameter int COOLDOWN       = 25_000_000
) (
   input logic           clk,
   input logic           reset,
   score_keeper_if.slave bus
);
   localparam int CW = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;
   localparam logic [CW-1:0] CLOAD = CW'(COOLDOWN - 1);
   localparam logic [9:0] PV = 10'(PONTOS_VITORIA);
   typedef enum logic [1:0] {JOGANDO, PAUSA, FIM} state_t;
   state_t state, nxt;
   logic s1, s2, d1, d2, e1, e2, w1, w2;
   logic [CW-1:0] cnt, cnt_n;
   logic [9:0] sc1, sc2, sc1_n, sc2_n, a1, a2;
   logic [1:0] ven, ven_n;
   logic pon, pon_n, pau, fim;
   function automatic logic [9:0] sat(input logic [9:0] v);
      return v >= 10'd999 ? v : v + 10'd1;
   endfunction
   assign e1 = s1 & ~d1;
   assign e2 = s2 & ~d2;
   assign a1 = e2 ? sat(sc1) : sc1;
   assign a2 = e1 ? sat(sc2) : sc2;
   assign w1 = a1 == PV;
   assign w2 = a2 == PV;
   always_comb begin
      nxt   = state;
      cnt_n = cnt;
      sc1_n = sc1;
      sc2_n = sc2;
      ven_n = ven;
      pon_n = 1'b0;
      if (bus.novo_jogo) begin
         nxt   = JOGANDO;
         cnt_n = '0;
         sc1_n = '0;
         sc2_n = '0;
         ven_n = 2'b00;
      end else if (state == JOGANDO && (e1 || e2)) begin
         sc1_n = a1;
         sc2_n = a2;
         pon_n = (a1 != sc1) || (a2 != sc2);
         nxt   = (w1 || w2) ? FIM : PAUSA;
         ven_n = (w1 || w2) ? {w2, w1} : ven;
         cnt_n = (w1 || w2) ? cnt : CLOAD;
      end else if (state == PAUSA) begin
         nxt   = cnt == '0 ? JOGANDO : PAUSA;
         cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      end
   end
   // pausa/fim_jogo are registered copies of the next state so they never glitch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {s1, s2, d1, d2} <= '0;
         state <= JOGANDO;
         cnt   <= '0;
         sc1   <= '0;
         sc2   <= '0;
         ven   <= 2'b00;
         pon   <= 1'b0;
         pau   <= 1'b0;
         fim   <= 1'b0;
      end else begin
         s1    <= bus.colisao1;
         s2    <= bus.colisao2;
         d1    <= s1;
         d2    <= s2;
         state <= nxt;
         cnt   <= cnt_n;
         sc1   <= sc1_n;
         sc2   <= sc2_n;
         ven   <= ven_n;
         pon   <= pon_n;
         pau   <= nxt == PAUSA;
         fim   <= nxt == FIM;
      end
   end
   assign bus.score1   = sc1;
   assign bus.score2   = sc2;
   assign bus.vencedor = ven;
   assign bus.ponto    = pon;
   assign bus.pausa    = pau;
   assign bus.fim_jogo = fim;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed points with a scoreboard checking every ponto pulse against queued expectations
module tb_score_keeper;
   logic clk = 1'b0;
   logic reset = 1'b1;
   score_keeper_if bus ();
   score_keeper #(.PONTOS_VITORIA(3), .COOLDOWN(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   logic [23:0] exp_q[$];
   int s_cmp = 0, s_bad = 0, m_cmp = 0, m_bad = 0;
   function automatic logic [23:0] pk(int a, int b, int v, int f, int p);
      return {10'(a), 10'(b), 2'(v), 1'(f), 1'(p)};
   endfunction
   initial forever begin
      @(negedge clk);
      if (!reset && bus.ponto) begin
         m_cmp++;
         if (exp_q.size() == 0) begin
            m_bad++;
            $display("FAIL unexpected_ponto got s1=%0d s2=%0d ven=%0d need no point", bus.score1, bus.score2, bus.vencedor);
         end else begin
            logic [23:0] e, g;
            e = exp_q.pop_front();
            g = {bus.score1, bus.score2, bus.vencedor, bus.fim_jogo, bus.pausa};
            if (g !== e) begin
               m_bad++;
               $display("FAIL point got s1=%0d s2=%0d ven=%0d fim=%0d pausa=%0d need s1=%0d s2=%0d ven=%0d fim=%0d pausa=%0d",
                        g[23:14], g[13:4], g[3:2], g[1], g[0], e[23:14], e[13:4], e[3:2], e[1], e[0]);
            end
         end
      end
   end
   task automatic chk(input string name, input int act, input int req);
      s_cmp++;
      if (act != req) begin
         s_bad++;
         $display("FAIL %s got %0d need %0d", name, act, req);
      end
   endtask
   task automatic pulse(input bit a, input bit b);
      @(posedge clk); #1;
      bus.colisao1 = a;
      bus.colisao2 = b;
      @(posedge clk); #1;
      bus.colisao1 = 1'b0;
      bus.colisao2 = 1'b0;
   endtask
   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.pausa) n++;
         else if (n > 0) break;
      end
   endtask
   task automatic wait_ponto();
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.ponto;
      end
      chk("ponto_timeout", int'(seen), 1);
   endtask
   task automatic new_game();
      @(posedge clk); #1;
      bus.novo_jogo = 1'b1;
      @(posedge clk); #1;
      bus.novo_jogo = 1'b0;
      @(negedge clk);
      chk("ng_score1", bus.score1, 0);
      chk("ng_score2", bus.score2, 0);
      chk("ng_vencedor", bus.vencedor, 0);
      chk("ng_fim", bus.fim_jogo, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL global_timeout got running need finished");
      $fatal(1, "timeout");
   end
   initial begin
      int n;
      bus.colisao1 = 1'b0;
      bus.colisao2 = 1'b0;
      bus.novo_jogo = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {bus.score1, bus.score2, bus.vencedor, bus.ponto, bus.pausa, bus.fim_jogo}, 0);
      reset = 1'b0;
      exp_q.push_back(pk(1, 0, 0, 0, 1));
      pulse(0, 1);
      wait_idle(n);
      chk("pause_len", n, 4);
      chk("single_score1", bus.score1, 1);
      exp_q.push_back(pk(1, 1, 0, 0, 1));
      @(posedge clk); #1;
      bus.colisao1 = 1'b1;
      repeat (20) @(posedge clk);
      #1 bus.colisao1 = 1'b0;
      wait_idle(n);
      chk("held_score2", bus.score2, 1);
      new_game();
      exp_q.push_back(pk(1, 0, 0, 0, 1));
      pulse(0, 1);
      wait_ponto();
      bus.colisao2 = 1'b1;
      @(posedge clk); #1;
      bus.colisao2 = 1'b0;
      wait_idle(n);
      chk("discard_score1", bus.score1, 1);
      exp_q.push_back(pk(2, 0, 0, 0, 1));
      pulse(0, 1);
      wait_idle(n);
      chk("fresh_score1", bus.score1, 2);
      exp_q.push_back(pk(3, 0, 1, 1, 0));
      pulse(0, 1);
      wait_idle(n);
      pulse(1, 0);
      repeat (6) @(negedge clk);
      chk("fim_score2", bus.score2, 0);
      chk("fim_hold", bus.fim_jogo, 1);
      chk("fim_vencedor", bus.vencedor, 1);
      new_game();
      exp_q.push_back(pk(0, 1, 0, 0, 1));
      pulse(1, 0);
      wait_idle(n);
      exp_q.push_back(pk(1, 1, 0, 0, 1));
      pulse(0, 1);
      wait_idle(n);
      exp_q.push_back(pk(1, 2, 0, 0, 1));
      pulse(1, 0);
      wait_idle(n);
      exp_q.push_back(pk(2, 2, 0, 0, 1));
      pulse(0, 1);
      wait_idle(n);
      exp_q.push_back(pk(3, 3, 3, 1, 0));
      pulse(1, 1);
      repeat (4) @(negedge clk);
      chk("tie_vencedor", bus.vencedor, 3);
      new_game();
      @(posedge clk); #1;
      bus.colisao1 = 1'b1;
      @(posedge clk); #1;
      bus.novo_jogo = 1'b1;
      @(posedge clk); #1;
      bus.novo_jogo = 1'b0;
      bus.colisao1 = 1'b0;
      repeat (8) @(negedge clk);
      chk("prio_score2", bus.score2, 0);
      chk("prio_pausa", bus.pausa, 0);
      exp_q.push_back(pk(1, 0, 0, 0, 1));
      pulse(0, 1);
      wait_ponto();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst", {bus.score1, bus.score2, bus.vencedor, bus.ponto, bus.pausa, bus.fim_jogo}, 0);
      bus.colisao1 = 1'b1;
      exp_q.push_back(pk(0, 1, 0, 0, 1));
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      bus.colisao1 = 1'b0;
      chk("held_rst_score2", bus.score2, 1);
      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", s_cmp + m_cmp, s_bad + m_bad);
      $finish;
   end
endmodule
